// File: rtl/freq_div_prog.sv
// Multi-channel programmable clock divider / tone generator.
// Each channel emits a ~50% square wave and a per-period tick; new periods apply only at period boundaries.
module freq_div_prog #(
    parameter int CH      = 2,
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 50,
    parameter int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    en,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ready,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);

    logic [CNT_W-1:0] r_cnt      [CH];
    logic [CNT_W-1:0] r_per      [CH];
    logic [CNT_W-1:0] r_pend_val [CH];
    logic [CH-1:0]    r_pend;
    logic [CH-1:0]    w_accept;

    // Out-of-range channel indices match no channel, so the write is dropped with ready high.
    always_comb begin
        div_ready = 1'b1;
        w_accept  = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (div_ch == CH_W'(c)) begin
                div_ready   = ~r_pend[c];
                w_accept[c] = div_wr & ~r_pend[c];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CNT_W-1:0] w_half;
        logic [CNT_W-1:0] w_last;
        logic             w_active;
        logic             w_wrap;

        assign w_half   = r_per[g] >> 1;
        assign w_last   = r_per[g] - CNT_W'(1);
        assign w_active = en[g] && (r_per[g] >= CNT_W'(2));
        assign w_wrap   = w_active && (r_cnt[g] == w_last);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[g]      <= '0;
                r_per[g]      <= CNT_W'(DEF_DIV);
                r_pend_val[g] <= '0;
                r_pend[g]     <= 1'b0;
                clk_out[g]    <= 1'b0;
                tick[g]       <= 1'b0;
            end else begin
                if (w_active) begin
                    clk_out[g] <= (r_cnt[g] < w_half);
                    tick[g]    <= w_wrap;
                    r_cnt[g]   <= w_wrap ? '0 : r_cnt[g] + CNT_W'(1);
                end else begin
                    clk_out[g] <= 1'b0;
                    tick[g]    <= 1'b0;
                    r_cnt[g]   <= '0;
                end
                // Apply needs pending set while accept needs it clear, so the two are exclusive.
                if (r_pend[g] && (w_wrap || !w_active)) begin
                    r_per[g]  <= r_pend_val[g];
                    r_pend[g] <= 1'b0;
                end else if (w_accept[g]) begin
                    r_pend_val[g] <= div_val;
                    r_pend[g]     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog: a time-based reference model predicts every cycle's outputs,
// a monitor on the falling edge pops and compares them.
module tb_freq_div_prog;

    localparam int CH      = 3;
    localparam int CNT_W   = 32;
    localparam int DEF_DIV = 50;
    localparam int CH_W    = 2;

    logic             clk;
    logic             rst_n;
    logic [CH-1:0]    en;
    logic             div_wr;
    logic [CH_W-1:0]  div_ch;
    logic [CNT_W-1:0] div_val;
    logic             div_ready;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;

    freq_div_prog #(.CH(CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_wr    (div_wr),
        .div_ch    (div_ch),
        .div_val   (div_val),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] co;
        logic [CH-1:0] tk;
        logic          rdy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each channel remembers the cycle its current period began; position is elapsed time.
    longint unsigned cyc = 0;
    longint unsigned m_per   [CH];
    longint unsigned m_pv    [CH];
    longint unsigned m_start [CH];
    bit              m_pend  [CH];

    always @(posedge clk) begin : model
        exp_t            e;
        longint unsigned pos;
        bit              acc;
        bit              run;
        bit              bnd;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            if (!rst_n) begin
                m_per[c]   = DEF_DIV;
                m_pv[c]    = 0;
                m_pend[c]  = 0;
                m_start[c] = cyc + 1;
            end else begin
                pos = cyc - m_start[c];
                acc = div_wr && (int'(div_ch) == c) && !m_pend[c];
                run = en[c] && (m_per[c] >= 2);
                bnd = 1'b1;
                if (run) begin
                    e.co[c] = (pos < m_per[c] / 2);
                    bnd     = (pos == m_per[c] - 1);
                    e.tk[c] = bnd;
                end
                if (bnd) m_start[c] = cyc + 1;
                if (m_pend[c] && bnd) begin
                    m_per[c]  = m_pv[c];
                    m_pend[c] = 0;
                end
                if (acc) begin
                    m_pend[c] = 1;
                    m_pv[c]   = div_val;
                end
            end
        end
        if (int'(div_ch) >= CH) e.rdy = 1'b1;
        else                    e.rdy = !m_pend[div_ch];
        q.push_back(e);
        cyc++;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("clk_out", clk_out, e.co);
            chk("tick", tick, e.tk);
            chk("div_ready", div_ready, e.rdy);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Holds the write until the handshake completes, like a compliant master.
    task automatic wr(input int ch, input longint unsigned v);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        div_wr  = 1'b1;
        div_ch  = CH_W'(ch);
        div_val = CNT_W'(v);
        while (!acc && n < 300) begin
            @(posedge clk);
            acc = div_ready;
            n++;
            @(negedge clk);
            #1;
        end
        div_wr = 1'b0;
        if (!acc) chk("wr_timeout", 0, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = '0;
        div_wr  = 1'b0;
        div_ch  = '0;
        div_val = '0;
        idle(3);
        rst_n = 1'b1;

        en = 3'b001;
        idle(120);
        idle(10);
        wr(0, 5);
        idle(40);
        wr(0, 3);
        wr(0, 8);
        idle(40);
        wr(0, 0);
        idle(60);
        wr(0, 4);
        idle(30);

        en = 3'b111;
        idle(17);
        wr(0, 6);
        wr(1, 9);
        wr(3, 9);
        wr(3, 2);
        idle(60);
        wr(2, 64'hFFFF_FFFF);
        wr(1, 1);
        idle(100);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) en[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) wr($urandom_range(0, 3), $urandom_range(0, 12));
            else idle(1);
        end

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        en = 3'b001;
        idle(5);
        div_wr  = 1'b1;
        div_ch  = '0;
        div_val = 32'd7;
        idle(1);
        div_wr = 1'b0;
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", clk_out, 0);
        chk("async_rst_tick", tick, 0);
        chk("async_rst_ready", div_ready, 1);
        idle(2);
        rst_n = 1'b1;
        idle(130);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
